// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and depth helper, used by the FIFO and the UART top.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;
   localparam int unsigned FIFO_ADDR_WIDTH = 6;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_PUSH,
      OP_POP,
      OP_BOTH,
      OP_FLUSH
   } fifo_op_e;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, read port either registered
// (REG_READ=1, with enable and async reset) or asynchronous (REG_READ=0).
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int unsigned REG_READ   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   generate
      if (REG_READ != 0) begin : g_reg_read
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data <= '0;
            end else if (rd_en) begin
               rd_data <= mem[rd_addr];
            end
         end
      end else begin : g_async_read
         // Enable and reset only apply to the registered port.
         logic unused_ctrl;
         assign unused_ctrl = rst ^ rd_en;
         assign rd_data     = mem[rd_addr];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with almost flags, sticky error flags,
// synchronous flush and selectable first-word-fall-through read mode.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH    = FIFO_ADDR_WIDTH,
   parameter int unsigned FWFT          = 0,
   parameter int unsigned AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 4,
   parameter int unsigned AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] buf_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] buf_out,
   output logic                  buf_empty,
   output logic                  buf_full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   fifo_counter,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THRESH);
   localparam logic          AFULL_RST  = (AFULL_THRESH == 0);

   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
   logic [CW-1:0]         count, count_nxt;
   logic                  rd_ok, rd_acc, wr_acc;
   logic                  ovf_evt, udf_evt;
   fifo_op_e              op;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;

   // Flush overrides both requests, so nothing is accepted or flagged with it.
   always_comb begin
      rd_ok   = rd_en & ~buf_empty;
      rd_acc  = ~flush & rd_ok;
      wr_acc  = ~flush & wr_en & (~buf_full | rd_ok);
      ovf_evt = ~flush & wr_en & buf_full & ~rd_ok;
      udf_evt = ~flush & rd_en & buf_empty;
   end

   always_comb begin
      op = OP_IDLE;
      if (flush) begin
         op = OP_FLUSH;
      end else if (wr_acc && rd_acc) begin
         op = OP_BOTH;
      end else if (wr_acc) begin
         op = OP_PUSH;
      end else if (rd_acc) begin
         op = OP_POP;
      end
   end

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      case (op)
         OP_FLUSH: begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
         end
         OP_PUSH: begin
            wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
            count_nxt  = count + CW'(1);
         end
         OP_POP: begin
            rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
            count_nxt  = count - CW'(1);
         end
         OP_BOTH: begin
            wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
            rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         buf_empty    <= 1'b1;
         buf_full     <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= AFULL_RST;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         count        <= count_nxt;
         buf_empty    <= (count_nxt == '0);
         buf_full     <= (count_nxt == DEPTH_C);
         almost_empty <= (count_nxt <= AEMPTY_C);
         almost_full  <= (count_nxt >= AFULL_C);
         overflow     <= ovf_evt | (overflow & ~err_clr);
         underflow    <= udf_evt | (underflow & ~err_clr);
      end
   end

   assign fifo_counter = count;

   // FWFT looks ahead at the next head address; standard mode reads the current head.
   assign ram_rd_addr = (FWFT != 0) ? rd_ptr_nxt : rd_ptr;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_READ   ((FWFT == 0) ? 1 : 0)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (buf_in),
      .rd_en   (rd_acc),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_q)
   );

   generate
      if (FWFT == 0) begin : g_std_out
         assign buf_out = ram_q;
      end else begin : g_fwft_out
         logic [DATA_WIDTH-1:0] head_q;

         // Next head is the word being written this edge only when it lands
         // exactly at the next read address; bypass the RAM in that case.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               head_q <= '0;
            end else if (count_nxt != '0) begin
               head_q <= (wr_acc && (wr_ptr == rd_ptr_nxt)) ? buf_in : ram_q;
            end
         end

         assign buf_out = head_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: standard and FWFT instances driven
// by one stimulus stream, checked against a queue scoreboard and a vector table.
module tb_sync_fifo_param;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;

   logic          clk;
   logic          rst;
   logic [DW-1:0] buf_in;
   logic          wr_en, rd_en, flush, err_clr;

   logic [DW-1:0] s_buf_out, f_buf_out;
   logic          s_buf_empty, s_buf_full, s_almost_empty, s_almost_full;
   logic          f_buf_empty, f_buf_full, f_almost_empty, f_almost_full;
   logic [AW:0]   s_fifo_counter, f_fifo_counter;
   logic          s_overflow, s_underflow, f_overflow, f_underflow;

   sync_fifo_param #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FWFT       (0)
   ) dut_std (
      .clk          (clk),
      .rst          (rst),
      .buf_in       (buf_in),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .flush        (flush),
      .err_clr      (err_clr),
      .buf_out      (s_buf_out),
      .buf_empty    (s_buf_empty),
      .buf_full     (s_buf_full),
      .almost_empty (s_almost_empty),
      .almost_full  (s_almost_full),
      .fifo_counter (s_fifo_counter),
      .overflow     (s_overflow),
      .underflow    (s_underflow)
   );

   sync_fifo_param #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FWFT       (1)
   ) dut_fwft (
      .clk          (clk),
      .rst          (rst),
      .buf_in       (buf_in),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .flush        (flush),
      .err_clr      (err_clr),
      .buf_out      (f_buf_out),
      .buf_empty    (f_buf_empty),
      .buf_full     (f_buf_full),
      .almost_empty (f_almost_empty),
      .almost_full  (f_almost_full),
      .fifo_counter (f_fifo_counter),
      .overflow     (f_overflow),
      .underflow    (f_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic          rd;
      logic          fl;
      logic          ec;
      logic [DW-1:0] din;
      int unsigned   cnt;
      logic          ovf;
      logic          udf;
      logic          chk_out;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t          vecs [12];
   logic [DW-1:0] sb [$];
   logic [DW-1:0] std_last, f_last;
   logic          m_ovf, m_udf;
   int unsigned   n_pass, n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_status();
      int unsigned n;
      n = sb.size();
      check("count",      32'(s_fifo_counter), n);
      check("empty",      32'(s_buf_empty),    32'(n == 0));
      check("full",       32'(s_buf_full),     32'(n == DEPTH));
      check("aempty",     32'(s_almost_empty), 32'(n <= 4));
      check("afull",      32'(s_almost_full),  32'(n >= 60));
      check("overflow",   32'(s_overflow),     32'(m_ovf));
      check("underflow",  32'(s_underflow),    32'(m_udf));
      check("std_out",    32'(s_buf_out),      32'(std_last));
      check("fwft_out",   32'(f_buf_out),      32'(f_last));
      check("fwft_count", 32'(f_fifo_counter), n);
      check("fwft_flags",
            32'({f_buf_empty, f_buf_full, f_almost_empty, f_almost_full, f_overflow, f_underflow}),
            32'({n == 0, n == DEPTH, n <= 4, n >= 60, m_ovf, m_udf}));
   endtask

   task automatic model_clear();
      sb.delete();
      std_last = '0;
      f_last   = '0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
   endtask

   // Drive one cycle, update the scoreboard, check #1 after the edge.
   task automatic step(input logic wr, input logic rd, input logic fl, input logic ec,
                       input logic [DW-1:0] din);
      int unsigned n;
      bit rdok;
      bit wrok;
      wr_en   = wr;
      rd_en   = rd;
      flush   = fl;
      err_clr = ec;
      buf_in  = din;
      n       = sb.size();
      if (fl) begin
         sb.delete();
         m_ovf = m_ovf && !ec;
         m_udf = m_udf && !ec;
      end else begin
         rdok  = rd && (n != 0);
         wrok  = wr && ((n < DEPTH) || rdok);
         m_udf = (rd && (n == 0)) || (m_udf && !ec);
         m_ovf = (wr && (n == DEPTH) && !rdok) || (m_ovf && !ec);
         if (rdok) std_last = sb.pop_front();
         if (wrok) sb.push_back(din);
      end
      if (sb.size() != 0) f_last = sb[0];
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      check_status();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      flush   = 1'b0;
      err_clr = 1'b0;
      buf_in  = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_status();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      //            wr    rd    fl    ec    din      cnt ovf   udf   chk   dout
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1,   1, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   0, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd7,   1, 1'b0, 1'b1, 1'b0, 16'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   0, 1'b0, 1'b1, 1'b1, 16'd7};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   0, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd11,  1, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd12,  2, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd13,  3, 1'b0, 1'b0, 1'b0, 16'd0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd99,  0, 1'b0, 1'b0, 1'b1, 16'd7};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   0, 1'b0, 1'b1, 1'b1, 16'd7};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0,   0, 1'b0, 1'b1, 1'b0, 16'd0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0,   0, 1'b0, 1'b0, 1'b0, 16'd0};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].ec, vecs[i].din);
         check($sformatf("vec%0d_count", i), 32'(s_fifo_counter), vecs[i].cnt);
         check($sformatf("vec%0d_ovf", i),   32'(s_overflow),     32'(vecs[i].ovf));
         check($sformatf("vec%0d_udf", i),   32'(s_underflow),    32'(vecs[i].udf));
         if (vecs[i].chk_out)
            check($sformatf("vec%0d_out", i), 32'(s_buf_out), 32'(vecs[i].dout));
      end

      // Fill to full, overflow, then drain in order.
      do_reset();
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'((i + 1) * 10));
      check("fill_full",  32'(s_buf_full),  32'd1);
      check("fill_afull", 32'(s_almost_full), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'd999);
      check("push65_ovf",   32'(s_overflow),     32'd1);
      check("push65_count", 32'(s_fifo_counter), 32'd64);
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
         check("drain_data", 32'(s_buf_out), 32'((i + 1) * 10));
      end
      check("drain_empty", 32'(s_buf_empty), 32'd1);

      // Simultaneous push/pop at full, crossing pointer wrap.
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'(100 + i));
      for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'(500 + i));
      check("rot_count", 32'(s_fifo_counter), 32'd64);
      check("rot_ovf",   32'(s_overflow),     32'd0);
      for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

      // FWFT head presentation.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A5);
      check("fwft_first", 32'(f_buf_out), 32'h00A5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h003C);
      check("fwft_hold", 32'(f_buf_out), 32'h00A5);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      check("fwft_next", 32'(f_buf_out), 32'h003C);
      check("std_pop",   32'(s_buf_out), 32'h00A5);

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'(40 + i));
      wr_en  = 1'b1;
      buf_in = 16'h0077;
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      check_status();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rst   = 1'b0;
      check_status();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
